// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states
// and the big-endian byte-lane index helper.
package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR,
        RESP
    } lsu_state_t;

    // Big-endian memory: byte offset 0 is bits 31:24, so lane k starts at bit 24-8k.
    function automatic logic [4:0] lane_lsb(input logic [1:0] off);
        return {~off, 3'b000};
    endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Combinational lane logic: extracts and extends load data from a memory word and
// merges sub-word store data into the word read back for read-modify-write.
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [1:0]  i_offset,
    input  logic [31:0] i_mem_word,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merge_data
);

    logic [4:0]  w_byte_lsb;
    logic [4:0]  w_half_lsb;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte_lsb = lane_lsb(i_offset);
    // A halfword occupies the byte lane just below its odd partner: offset 0 -> bit 16, offset 2 -> bit 0.
    assign w_half_lsb = lane_lsb({i_offset[1], 1'b1});
    assign w_byte     = 8'(i_mem_word >> w_byte_lsb);
    assign w_half     = 16'(i_mem_word >> w_half_lsb);

    always_comb begin
        o_load_data  = i_mem_word;
        o_merge_data = i_store_data;
        case (i_size)
            SZ_BYTE: begin
                o_load_data  = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
                o_merge_data = (i_mem_word & ~(32'h0000_00FF << w_byte_lsb))
                             | ({24'd0, i_store_data[7:0]} << w_byte_lsb);
            end
            SZ_HALF: begin
                o_load_data  = {{16{w_half[15] & ~i_unsigned}}, w_half};
                o_merge_data = (i_mem_word & ~(32'h0000_FFFF << w_half_lsb))
                             | ({16'd0, i_store_data[15:0]} << w_half_lsb);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store sequencer for a big-endian word-wide memory; sub-word stores use
// read-modify-write. Define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_READ_WAIT = 1,
    parameter int ADDR_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              misalign_exc,
    output logic [ADDR_W-1:0] mem_address,
    output logic [31:0]       mem_writedata,
    output logic              mem_writeenable,
    output logic              mem_read,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0] RD_CNT_INIT = 3'(MEM_READ_WAIT - 1);

    lsu_state_t        r_state;
    lsu_state_t        w_next;
    logic [2:0]        r_cnt;
    logic              r_exc;
    logic              r_is_store;
    logic              r_unsigned;
    logic [1:0]        r_size;
    logic [1:0]        r_off;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rsp_rdata;
    logic [31:0]       r_mem_writedata;
    logic [ADDR_W-1:0] r_mem_address;

    logic [1:0]        w_size;
    logic [1:0]        w_off;
    logic              w_accept;
    logic              w_word_store;
    logic              w_trap;
    logic              w_rd_last;
    logic [31:0]       w_load_data;
    logic [31:0]       w_merge_data;

    assign w_size       = (req_size == 2'b11) ? SZ_WORD : req_size;
    assign w_accept     = req_valid && (r_state == IDLE);
    assign w_word_store = req_is_store && (w_size == SZ_WORD);
    assign w_rd_last    = (r_state == RD_WAIT) && (r_cnt == 3'd0);

    // Misaligned low bits are dropped, forcing natural alignment for half and word.
    always_comb begin
        case (w_size)
            SZ_BYTE: w_off = req_addr[1:0];
            SZ_HALF: w_off = {req_addr[1], 1'b0};
            default: w_off = 2'b00;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_trap = ((w_size == SZ_HALF) && req_addr[0])
                 || ((w_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
    assign w_trap = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_trap)            w_next = RESP;
                    else if (w_word_store) w_next = WR;
                    else                   w_next = RD_WAIT;
                end
            end
            RD_WAIT: if (w_rd_last) w_next = r_is_store ? WR : RESP;
            WR:      w_next = RESP;
            RESP:    w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt           <= '0;
            r_exc           <= 1'b0;
            r_rsp_rdata     <= '0;
            r_mem_address   <= '0;
            r_mem_writedata <= '0;
        end else if (w_accept) begin
            r_cnt         <= RD_CNT_INIT;
            r_exc         <= w_trap;
            r_rsp_rdata   <= '0;
            r_mem_address <= {req_addr[ADDR_W-1:2], 2'b00};
            if (w_word_store) r_mem_writedata <= req_wdata;
        end else if (r_state == RD_WAIT) begin
            if (r_cnt != 3'd0)   r_cnt           <= r_cnt - 3'd1;
            else if (r_is_store) r_mem_writedata <= w_merge_data;
            else                 r_rsp_rdata     <= w_load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_is_store <= req_is_store;
            r_size     <= w_size;
            r_unsigned <= req_unsigned;
            r_off      <= w_off;
            r_wdata    <= req_wdata;
        end
    end

    lsu_lane_merge u_lane_merge (
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .i_offset     (r_off),
        .i_mem_word   (mem_rdata),
        .i_store_data (r_wdata),
        .o_load_data  (w_load_data),
        .o_merge_data (w_merge_data)
    );

    assign req_ready       = (r_state == IDLE);
    assign rsp_valid       = (r_state == RESP) && !r_exc;
    assign misalign_exc    = (r_state == RESP) && r_exc;
    assign rsp_rdata       = r_rsp_rdata;
    assign mem_address     = r_mem_address;
    assign mem_writedata   = r_mem_writedata;
    assign mem_writeenable = (r_state == WR);
    assign mem_read        = (r_state == RD_WAIT);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: bench-owned word memory, directed test-plan cases with
// literal expectations, then randomized requests checked every cycle against a model.
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int MRW = 1;
    localparam int AW  = 32;
`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic          clk;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_is_store;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          misalign_exc;
    logic [AW-1:0] mem_address;
    logic [31:0]   mem_writedata;
    logic          mem_writeenable;
    logic          mem_read;
    logic [31:0]   mem_rdata;

    load_store_unit #(.MEM_READ_WAIT(MRW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .misalign_exc(misalign_exc), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_writeenable(mem_writeenable),
        .mem_read(mem_read), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Memory: 16 words indexed by address bits 5:2; read data only valid once the
    // address has been held for MRW cycles.
    logic [31:0] phys [16];
    logic [31:0] refm [16];
    int rd_run = 0;
    int we_rises = 0;

    always @(posedge clk) begin
        if (mem_writeenable) phys[mem_address[5:2]] <= mem_writedata;
        rd_run <= mem_read ? rd_run + 1 : 0;
    end
    always @(posedge mem_writeenable) we_rises++;
    assign mem_rdata = (mem_read && rd_run == MRW - 1) ? phys[mem_address[5:2]] : 32'h5A5A_5A5A;

    // Reference model: on acceptance, work out from the access rules what every output
    // must do at each cycle T+n, then check the DUT on every falling edge.
    bit          busy = 1'b0;
    int          age, e_ws, e_rv, e_rd, e_widx;
    bit          e_exc;
    logic [31:0] e_addr, e_wdata, e_rdata;
    int          n_acc = 0;

    always @(negedge clk) begin
        bit x_rv, x_ex, x_we, x_rd, x_rdy, mis;
        int sz, off, sh;
        logic [31:0] old, v;
        x_rv = 0; x_ex = 0; x_we = 0; x_rd = 0; x_rdy = 1;
        if (reset) busy = 1'b0;
        if (busy) begin
            x_rdy = 0;
            x_rv  = (age == e_rv) && !e_exc;
            x_ex  = (age == e_rv) && e_exc;
            x_we  = (age == e_ws);
            x_rd  = (age >= 1) && (age <= e_rd);
            chk("mem_address", mem_address, e_addr);
            if (x_we) begin
                chk("mem_writedata", mem_writedata, e_wdata);
                refm[e_widx] = e_wdata;
            end
            if (x_rv) chk("rsp_rdata", rsp_rdata, e_rdata);
        end
        chk("req_ready", {31'd0, req_ready}, {31'd0, x_rdy});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, x_rv});
        chk("misalign_exc", {31'd0, misalign_exc}, {31'd0, x_ex});
        chk("mem_writeenable", {31'd0, mem_writeenable}, {31'd0, x_we});
        chk("mem_read", {31'd0, mem_read}, {31'd0, x_rd});
        if (busy) begin
            age++;
            if (age > e_rv) busy = 1'b0;
        end
        if (!busy && !reset && req_valid && req_ready) begin
            busy = 1'b1; age = 1; n_acc++;
            sz  = (req_size == 2'b11) ? 2 : int'(req_size);
            mis = (sz == 1 && req_addr[0]) || (sz == 2 && req_addr[1:0] != 2'b00);
            e_exc  = mis && TRAP;
            e_addr = req_addr & 32'hFFFF_FFFC;
            e_widx = int'(req_addr[5:2]);
            old    = refm[e_widx];
            off    = (sz == 0) ? int'(req_addr[1:0]) : (sz == 1) ? (req_addr[1] ? 2 : 0) : 0;
            sh     = (sz == 0) ? 8 * (3 - off) : 8 * (2 - off);
            e_ws = 0; e_rd = 0; e_rdata = 0; e_wdata = 0;
            if (e_exc) begin
                e_rv = 1;
            end else if (req_is_store && sz == 2) begin
                e_ws = 1; e_rv = 2; e_wdata = req_wdata;
            end else if (req_is_store) begin
                e_rd = MRW; e_ws = MRW + 1; e_rv = MRW + 2;
                if (sz == 0) e_wdata = (old & ~(32'hFF << sh)) | ((req_wdata & 32'hFF) << sh);
                else         e_wdata = (old & ~(32'hFFFF << sh)) | ((req_wdata & 32'hFFFF) << sh);
            end else begin
                e_rd = MRW; e_rv = MRW + 1;
                if (sz == 0) begin
                    v = (old >> sh) & 32'hFF;
                    if (!req_unsigned && v >= 32'h80) v = v | 32'hFFFF_FF00;
                end else if (sz == 1) begin
                    v = (old >> sh) & 32'hFFFF;
                    if (!req_unsigned && v >= 32'h8000) v = v | 32'hFFFF_0000;
                end else begin
                    v = old;
                end
                e_rdata = v;
            end
        end
    end

    task automatic do_req(input bit st, input logic [1:0] sz, input bit un,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output bit ex, output int lat);
        bit got;
        rd = 32'hX; ex = 0; lat = 0;
        @(posedge clk); #1;
        req_is_store = st; req_size = sz; req_unsigned = un;
        req_addr = a; req_wdata = wd; req_valid = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready) got = 1;
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: req_ready low for 20 cycles, required high");
        end else begin
            got = 0;
            for (int k = 0; k < 20 && !got; k++) begin
                @(negedge clk);
                lat++;
                if (rsp_valid || misalign_exc) begin
                    got = 1; rd = rsp_rdata; ex = misalign_exc;
                end
            end
            if (!got) begin
                n_cmp++; n_bad++;
                $display("FAIL response_timeout: no response in 20 cycles, required one");
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit ex;
        int lat, acc0, we0;
        bit got;
        reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 16; i++) begin
            phys[i] = $urandom;
            refm[i] = phys[i];
        end
        phys[4] = 32'h8899_AABB; refm[4] = 32'h8899_AABB;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_writedata", mem_writedata, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, ex, lat);
        chk("LW_0x10_data", rd, 32'h8899_AABB);
        chk("LW_0x10_latency", lat, 32'd2);
        chk("LW_0x10_mem_address", mem_address, 32'h10);
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, rd, ex, lat);
        chk("LB_0x11", rd, 32'hFFFF_FF99);
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, rd, ex, lat);
        chk("LBU_0x11", rd, 32'h0000_0099);
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, ex, lat);
        chk("LH_0x12", rd, 32'hFFFF_AABB);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, ex, lat);
        chk("LHU_0x12", rd, 32'h0000_AABB);

        we0 = we_rises;
        do_req(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00CC, rd, ex, lat);
        chk("SB_0x13_word", phys[4], 32'h8899_AACC);
        chk("SB_0x13_strobes", we_rises - we0, 32'd1);
        chk("SB_0x13_latency", lat, 32'd3);
        do_req(1'b1, 2'b01, 1'b0, 32'h10, 32'h0000_1234, rd, ex, lat);
        chk("SH_0x10_word", phys[4], 32'h1234_AACC);

        acc0 = n_acc;
        do_req(1'b1, 2'b10, 1'b0, 32'h20, 32'hDEAD_BEEF, rd, ex, lat);
        chk("SW_0x20_word", phys[8], 32'hDEAD_BEEF);
        chk("SW_0x20_latency", lat, 32'd2);
        chk("SW_0x20_rdata", rd, 32'd0);
        chk("SW_0x20_accepts", n_acc - acc0, 32'd1);

        do_req(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, rd, ex, lat);
        if (TRAP) chk("LW_0x12_exc", {31'd0, ex}, 32'd1);
        else      chk("LW_0x12_data", rd, 32'h1234_AACC);
        we0 = we_rises;
        do_req(1'b1, 2'b01, 1'b0, 32'h11, 32'h0000_5566, rd, ex, lat);
        if (TRAP) chk("SH_0x11_strobes", we_rises - we0, 32'd0);
        else      chk("SH_0x11_word", phys[4], 32'h5566_AACC);

        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'h8899_AABB, rd, ex, lat);
        we0 = we_rises;
        @(posedge clk); #1;
        req_is_store = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h13; req_wdata = 32'hCC; req_valid = 1'b1;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (req_ready) got = 1;
        end
        @(posedge clk); #1;
        chk("abort_in_rd_wait", {31'd0, mem_read}, 32'd1);
        reset = 1'b1; req_valid = 1'b0;
        #1;
        chk("abort_we_low", {31'd0, mem_writeenable}, 32'd0);
        chk("abort_ready_in_reset", {31'd0, req_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort_no_strobe", we_rises - we0, 32'd0);
        chk("abort_word_intact", phys[4], 32'h8899_AABB);
        chk("abort_ready_after", {31'd0, req_ready}, 32'd1);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(0, 63)))
                                            : (($urandom & 32'hFFFF_FF00) | 32'($urandom_range(0, 63)));
            do_req(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, rd, ex, lat);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) chk($sformatf("final_mem_%0d", i), phys[i], refm[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
